// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci BCD requester slice.
// Contents: default binary/BCD widths, index width, requester FSM state
// encoding and the response record (index, binary, BCD, error flag).
package fibo_pkg;

    localparam int unsigned DW   = 28;      // calculator fibo_out width
    localparam int unsigned ND   = 9;       // BCD digits, enough for 2^28-1
    localparam int unsigned BCDW = 4 * ND;  // packed BCD width
    localparam int unsigned NW   = 5;       // Fibonacci index width

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StStart,
        StWait,
        StConv,
        StResp
    } state_t;

    typedef struct packed {
        logic [NW-1:0]   n;
        logic [DW-1:0]   bin;
        logic [BCDW-1:0] bcd;
        logic            err;
    } resp_t;

endpackage

// File: rtl/fibo_bcd_requester_if.sv
// Request / calculator / response bundle of the Fibonacci BCD requester.
// master: the requester itself (drives REQ_READY, FIB_*, RESP_* outputs).
// slave : the surrounding system (sequencer, calculator, response sink).
interface fibo_bcd_requester_if #(
    parameter int unsigned DW = fibo_pkg::DW,
    parameter int unsigned ND = fibo_pkg::ND
);
    // Request side
    logic                   REQ_VALID;
    logic                   REQ_READY;
    logic [fibo_pkg::NW-1:0] REQ_N;
    // Calculator side
    logic                   FIB_CLR;
    logic                   FIB_START;
    logic [fibo_pkg::NW-1:0] FIB_INPUT_S;
    logic [DW-1:0]          FIB_DOUT;
    logic                   FIB_DONE;
    // Response side
    logic                   RESP_VALID;
    logic                   RESP_READY;
    logic [fibo_pkg::NW-1:0] RESP_N;
    logic [DW-1:0]          RESP_BIN;
    logic [4*ND-1:0]        RESP_BCD;
    logic                   RESP_ERR;

    modport master (
        input  REQ_VALID, REQ_N, FIB_DOUT, FIB_DONE, RESP_READY,
        output REQ_READY, FIB_CLR, FIB_START, FIB_INPUT_S,
               RESP_VALID, RESP_N, RESP_BIN, RESP_BCD, RESP_ERR
    );

    modport slave (
        output REQ_VALID, REQ_N, FIB_DOUT, FIB_DONE, RESP_READY,
        input  REQ_READY, FIB_CLR, FIB_START, FIB_INPUT_S,
               RESP_VALID, RESP_N, RESP_BIN, RESP_BCD, RESP_ERR
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to packed-BCD converter.
// One shift per cycle for DW cycles after start; digit 0 in bcd_o[3:0].
// Ports: clk_i clock, rst_ni synchronous active-low reset, start_i loads
// bin_i, busy_o high while shifting, done_o one-cycle pulse after the last
// shift, bcd_o result (valid from done_o until the next start_i).
module bin2bcd_seq #(
    parameter int unsigned DW = 28,
    parameter int unsigned ND = 9
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [DW-1:0]   bin_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [4*ND-1:0] bcd_o
);
    localparam int unsigned CNTW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CNTW-1:0] CntLast = CNTW'(DW - 1);

    logic [DW-1:0]   bin_q;
    logic [4*ND-1:0] bcd_q;
    logic [4*ND-1:0] bcd_adj;
    logic [CNTW-1:0] cnt_q;
    logic            busy_q;
    logic            done_q;

    // Add 3 to every digit >= 5 so the following shift carries correctly.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < ND; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                bin_q  <= bin_i;
                bcd_q  <= '0;
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                cnt_q          <= cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/fibo_bcd_requester.sv
// Initiator-side companion to fibonacci_calculator.
// Accepts an index over REQ_*, pulses FIB_CLR then FIB_START, waits for
// FIB_DONE (bounded by TIMEOUT cycles), converts the captured result to BCD
// and returns index/binary/BCD/error over RESP_*.
// Ports: CLK rising-edge clock, RST_N synchronous active-low reset,
// bus master modport of fibo_bcd_requester_if. All outputs are registered
// except REQ_READY, which is high exactly in the idle state.
module fibo_bcd_requester
    import fibo_pkg::*;
#(
    parameter int unsigned DW      = fibo_pkg::DW,
    parameter int unsigned ND      = fibo_pkg::ND,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    fibo_bcd_requester_if.master bus
);
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            fib_clr_q;
    logic            fib_start_q;
    logic [NW-1:0]   input_s_q;
    logic            resp_valid_q;
    logic [NW-1:0]   resp_n_q;
    logic [DW-1:0]   resp_bin_q;
    logic [4*ND-1:0] resp_bcd_q;
    logic            resp_err_q;

    logic            conv_start;
    logic            conv_busy;
    logic            conv_done;
    logic [4*ND-1:0] conv_bcd;

    // Done is only honoured in WAIT; a stale done from an earlier run is
    // cleared by the CLR pulse before WAIT is reached.
    assign conv_start = (state_q == StWait) && bus.FIB_DONE;

    bin2bcd_seq #(
        .DW (DW),
        .ND (ND)
    ) u_bin2bcd (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .start_i (conv_start),
        .bin_i   (bus.FIB_DOUT),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            fib_clr_q    <= 1'b0;
            fib_start_q  <= 1'b0;
            input_s_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_n_q     <= '0;
            resp_bin_q   <= '0;
            resp_bcd_q   <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            fib_clr_q   <= 1'b0;
            fib_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.REQ_VALID) begin
                        input_s_q  <= bus.REQ_N;
                        resp_n_q   <= bus.REQ_N;
                        resp_bin_q <= '0;
                        resp_bcd_q <= '0;
                        resp_err_q <= 1'b0;
                        fib_clr_q  <= 1'b1;
                        state_q    <= StClr;
                    end
                end
                StClr: begin
                    fib_start_q <= 1'b1;
                    state_q     <= StStart;
                end
                StStart: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    // Done takes priority over an expiring timeout.
                    if (bus.FIB_DONE) begin
                        resp_bin_q <= bus.FIB_DOUT;
                        state_q    <= StConv;
                    end else if (cnt_q == CntLast) begin
                        resp_err_q   <= 1'b1;
                        resp_bin_q   <= '0;
                        resp_bcd_q   <= '0;
                        resp_valid_q <= 1'b1;
                        state_q      <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StConv: begin
                    // The done pulse follows the final shift, when busy has dropped.
                    if (conv_done && !conv_busy) begin
                        resp_bcd_q   <= conv_bcd;
                        resp_valid_q <= 1'b1;
                        state_q      <= StResp;
                    end
                end
                StResp: begin
                    if (bus.RESP_READY) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.REQ_READY   = (state_q == StIdle);
    assign bus.FIB_CLR     = fib_clr_q;
    assign bus.FIB_START   = fib_start_q;
    assign bus.FIB_INPUT_S = input_s_q;
    assign bus.RESP_VALID  = resp_valid_q;
    assign bus.RESP_N      = resp_n_q;
    assign bus.RESP_BIN    = resp_bin_q;
    assign bus.RESP_BCD    = resp_bcd_q;
    assign bus.RESP_ERR    = resp_err_q;

endmodule

// File: tb/tb_fibo_bcd_requester.sv
// Bench for fibo_bcd_requester: behavioural calculator, arithmetic reference
// for Fibonacci values and decimal digits, directed plus randomized requests.
module tb_fibo_bcd_requester;
    import fibo_pkg::*;

    localparam int unsigned TO = 16;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    fibo_bcd_requester_if #(.DW(DW), .ND(ND)) bus ();

    fibo_bcd_requester #(
        .DW      (DW),
        .ND      (ND),
        .TIMEOUT (TO)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural calculator: mode 0 = true Fibonacci, 1 = forced value,
    // 2 = never finishes. Done appears calc_lat cycles after start is seen
    // and stays high until the next clear.
    int            calc_mode = 0;
    int            calc_lat  = 1;
    logic [DW-1:0] calc_val  = '0;
    logic          calc_done = 1'b0;
    logic          calc_run  = 1'b0;
    logic [DW-1:0] calc_dout = '0;
    int            calc_rem  = 0;

    function automatic logic [DW-1:0] fib(input int n);
        logic [DW-1:0] a = '0;
        logic [DW-1:0] b = DW'(1);
        logic [DW-1:0] t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [BCDW-1:0] to_bcd(input logic [DW-1:0] v);
        logic [BCDW-1:0] r = '0;
        int unsigned     x = 32'(v);
        for (int unsigned i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic resp_t mk(input logic [NW-1:0] n, input logic [DW-1:0] bin,
                                 input logic [BCDW-1:0] bcd, input logic err);
        resp_t r;
        r.n   = n;
        r.bin = bin;
        r.bcd = bcd;
        r.err = err;
        return r;
    endfunction

    always @(posedge CLK) begin
        if (bus.FIB_CLR) begin
            calc_done <= 1'b0;
            calc_dout <= '0;
            calc_run  <= 1'b0;
        end else if (bus.FIB_START) begin
            if (calc_mode != 2) begin
                calc_run <= 1'b1;
                calc_rem <= calc_lat;
            end
        end else if (calc_run) begin
            if (calc_rem <= 1) begin
                calc_run  <= 1'b0;
                calc_done <= 1'b1;
                calc_dout <= (calc_mode == 1) ? calc_val : fib(int'(bus.FIB_INPUT_S));
            end else begin
                calc_rem <= calc_rem - 1;
            end
        end
    end

    assign bus.FIB_DONE = calc_done;
    assign bus.FIB_DOUT = calc_dout;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_clr"},     64'(bus.FIB_CLR), 64'(0));
        chk({tag, "_start"},   64'(bus.FIB_START), 64'(0));
        chk({tag, "_input_s"}, 64'(bus.FIB_INPUT_S), 64'(0));
        chk({tag, "_rvalid"},  64'(bus.RESP_VALID), 64'(0));
        chk({tag, "_rn"},      64'(bus.RESP_N), 64'(0));
        chk({tag, "_rbin"},    64'(bus.RESP_BIN), 64'(0));
        chk({tag, "_rbcd"},    64'(bus.RESP_BCD), 64'(0));
        chk({tag, "_rerr"},    64'(bus.RESP_ERR), 64'(0));
        chk({tag, "_ready"},   64'(bus.REQ_READY), 64'(1));
    endtask

    // Holds REQ_VALID until the accept edge; returns at accept edge + 1.
    task automatic issue(input logic [NW-1:0] n, output int waited);
        waited        = 0;
        bus.REQ_VALID = 1'b1;
        bus.REQ_N     = n;
        while (!bus.REQ_READY && waited < 100) begin
            step();
            waited++;
        end
        chk("accept_bound", 64'(waited < 100), 64'(1));
        step();
        bus.REQ_VALID = 1'b0;
        bus.REQ_N     = '0;
    endtask

    // Starts just after the accept edge; exp_lat counts edges to RESP_VALID.
    task automatic expect_resp(input resp_t exp, input int exp_lat);
        int cyc = 0;
        chk("clr_pulse",     64'(bus.FIB_CLR), 64'(1));
        chk("start_in_clr",  64'(bus.FIB_START), 64'(0));
        chk("input_s",       64'(bus.FIB_INPUT_S), 64'(exp.n));
        chk("ready_busy",    64'(bus.REQ_READY), 64'(0));
        step();
        cyc++;
        chk("clr_drop",      64'(bus.FIB_CLR), 64'(0));
        chk("start_pulse",   64'(bus.FIB_START), 64'(1));
        step();
        cyc++;
        chk("start_drop",    64'(bus.FIB_START), 64'(0));
        while (!bus.RESP_VALID && cyc < 400) begin
            step();
            cyc++;
        end
        chk("latency",  64'(cyc), 64'(exp_lat));
        chk("resp_n",   64'(bus.RESP_N), 64'(exp.n));
        chk("resp_bin", 64'(bus.RESP_BIN), 64'(exp.bin));
        chk("resp_bcd", 64'(bus.RESP_BCD), 64'(exp.bcd));
        chk("resp_err", 64'(bus.RESP_ERR), 64'(exp.err));
    endtask

    task automatic handshake();
        bus.RESP_READY = 1'b1;
        step();
        bus.RESP_READY = 1'b0;
        chk("valid_drop", 64'(bus.RESP_VALID), 64'(0));
        chk("ready_back", 64'(bus.REQ_READY), 64'(1));
    endtask

    // Latency: CLR + START + W wait cycles + DW shifts + 1, where the
    // requester sees done one edge after the calculator raises it (W = lat+1).
    task automatic run(input logic [NW-1:0] n, input int mode, input logic [DW-1:0] val,
                       input int lat, input resp_t exp);
        int w;
        calc_mode = mode;
        calc_lat  = lat;
        calc_val  = val;
        issue(n, w);
        expect_resp(exp, (mode == 2) ? int'(2 + TO) : lat + 4 + int'(DW));
        handshake();
    endtask

    initial begin
        int            w;
        int            seen;
        logic [NW-1:0] rn;
        logic [DW-1:0] rv;
        int            rl;
        int            rm;
        logic [DW-1:0] eb;

        RST_N          = 1'b0;
        bus.REQ_VALID  = 1'b0;
        bus.REQ_N      = '0;
        bus.RESP_READY = 1'b0;
        repeat (2) step();
        check_zero("reset");
        RST_N = 1'b1;
        step();
        chk("idle_ready", 64'(bus.REQ_READY), 64'(1));

        // Directed values
        run(5'd20, 0, '0, 12, mk(5'd20, 28'd6765, 36'h000006765, 1'b0));
        run(5'd3, 1, 28'd9227465, 4, mk(5'd3, 28'd9227465, 36'h009227465, 1'b0));
        run(5'd31, 1, 28'h0FFFFFF, 2, mk(5'd31, 28'h0FFFFFF, to_bcd(28'h0FFFFFF), 1'b0));
        run(5'd9, 1, 28'hFFFFFFF, 1, mk(5'd9, 28'hFFFFFFF, 36'h268435455, 1'b0));
        run(5'd0, 1, 28'd0, 3, mk(5'd0, 28'd0, 36'h0, 1'b0));
        run(5'd1, 0, '0, 1, mk(5'd1, 28'd1, 36'h1, 1'b0));

        // Timeout, then a normal request completes
        run(5'd7, 2, '0, 1, mk(5'd7, 28'd0, 36'h0, 1'b1));
        run(5'd20, 0, '0, 6, mk(5'd20, 28'd6765, 36'h000006765, 1'b0));

        // Response back-pressure with a second request pending
        calc_mode = 0;
        calc_lat  = 5;
        issue(5'd10, w);
        expect_resp(mk(5'd10, 28'd55, 36'h55, 1'b0), 5 + 4 + int'(DW));
        bus.REQ_VALID = 1'b1;
        bus.REQ_N     = 5'd11;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", 64'(bus.RESP_VALID), 64'(1));
            chk("bp_n",     64'(bus.RESP_N), 64'(10));
            chk("bp_bin",   64'(bus.RESP_BIN), 64'(55));
            chk("bp_bcd",   64'(bus.RESP_BCD), 64'(36'h55));
            chk("bp_ready", 64'(bus.REQ_READY), 64'(0));
        end
        handshake();
        issue(5'd11, w);
        chk("b2b_accept_wait", 64'(w), 64'(0));
        expect_resp(mk(5'd11, 28'd89, 36'h89, 1'b0), 5 + 4 + int'(DW));
        handshake();

        // Randomized requests against the arithmetic reference
        for (int k = 0; k < 8; k++) begin
            rn = NW'($urandom_range(0, 31));
            rl = int'($urandom_range(1, 12));
            rm = int'($urandom_range(0, 1));
            rv = DW'($urandom) & 28'hFFFFFFF;
            eb = (rm == 1) ? rv : fib(int'(rn));
            run(rn, rm, rv, rl, mk(rn, eb, to_bcd(eb), 1'b0));
        end

        // Reset in the middle of conversion: no response must follow
        calc_mode = 0;
        calc_lat  = 3;
        issue(5'd15, w);
        repeat (17) step();
        RST_N = 1'b0;
        step();
        check_zero("rst_conv");
        RST_N = 1'b1;
        seen  = 0;
        repeat (60) begin
            step();
            if (bus.RESP_VALID || bus.FIB_CLR) seen++;
        end
        chk("no_spurious", 64'(seen), 64'(0));

        // Reset with stale done still high, idle a while, then a fresh run
        run(5'd8, 0, '0, 2, mk(5'd8, 28'd21, 36'h21, 1'b0));
        RST_N = 1'b0;
        step();
        check_zero("rst_stale");
        RST_N = 1'b1;
        seen  = 0;
        repeat (6) begin
            step();
            if (bus.RESP_VALID || bus.FIB_CLR || !bus.REQ_READY) seen++;
        end
        chk("stale_idle", 64'(seen), 64'(0));
        run(5'd12, 0, '0, 7, mk(5'd12, 28'd144, 36'h144, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
